load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access unit between the RV32I core and a word-wide memory bus. It consumes the memory-operation controls produced by the control unit: the request, the write flag and the 3-bit DATAMEMControl size/sign code (instruction funct3). It generates byte enables and a replicated write lane, and formats load data with sign or zero extension. It stalls the core while a bus transaction is outstanding and flags misaligned or illegal accesses without touching the bus.

## Interface
- TIMEOUT_CYCLES, 255, BUSY-state cycles without `bus_ack` before the access is aborted (used only with BUS_TIMEOUT_EN); range 1..65535
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  core requests a load or store this cycle
- mem_write  in  1  1 = store, 0 = load
- DATAMEMControl  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal; only 000/001/010 are legal for stores
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- stall  out  1  holds the core PC and pipeline
- rdata  out  32  extended load result; valid while `done` = 1
- done  out  1  one-cycle completion strobe
- misalign_err  out  1  pulses with `done` for a misaligned or illegal access
- bus_err  out  1  pulses with `done` on bus timeout
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  bus write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion; one-cycle pulse
- bus_rdata  in  32  read word; valid with `bus_ack`

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - On `req_valid`, latch `mem_write`, `DATAMEMControl`, `addr[1:0]` and `wdata`.
  - Legal access: load the bus registers and go to BUSY.
  - Misaligned or illegal access: set the error flag and go to DONE.
- **Misaligned** means: H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠00.
- **BUSY**
  - `bus_req`=1; address, enables and data are held stable.
  - On `bus_ack`: capture the formatted `bus_rdata` (loads), drop `bus_req`, go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then return to IDLE.
  - `req_valid` is ignored in DONE; that cycle completes the same instruction.
- **stall** = (IDLE & req_valid) | BUSY. It is combinational so the first cycle is held.
- **Byte enables**
  - B: 4'b0001 << addr[1:0].
  - H: addr[1] ? 1100 : 0011.
  - W: 1111.
  - For loads, `bus_be` is driven the same way; memory may ignore it.
- **Store data**
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- **Load data**
  - Select the byte lane from addr[1:0] and the half lane from addr[1].
  - B/H sign-extend; BU/HU zero-extend.
  - Errored or aborted loads return `rdata`=0.

## Timing
- Reset values: state IDLE, and `stall`, `done`, `misalign_err`, `bus_err`, `bus_req`, `bus_we` all 0. `bus_addr`, `bus_be`, `bus_wdata` and `rdata` reset to 0.
- Legal access:
  - Request seen at edge 0.
  - `bus_req` is high from cycle 1.
  - `bus_ack` arrives in cycle k ≥ 1.
  - `done` in cycle k+1.
  - The core is stalled from cycle 0 through cycle k, so the minimum stall is 2 cycles.
- Illegal access: `done` and `misalign_err` in cycle 1; stall is 1 cycle; no `bus_req`.
- `bus_ack` outside BUSY is ignored.
- Reset mid-transaction: `bus_req` drops at the next edge and the access is abandoned with no `done`. The bus owner tolerates an orphaned request.

## Configuration
- **BUS_TIMEOUT_EN defined:**
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop `bus_req`, go to DONE with `bus_err`=1 and `rdata`=0.
  - If ack and terminal count coincide, ack wins and there is no error.
- **Undefined:** no counter; BUSY waits indefinitely; `bus_err` is tied 0.

## Test plan
- LB at addr 0x103, `bus_rdata`=0x80FF_1234, ack after 3 cycles -> `bus_be`=1000, `bus_addr`=0x100, `rdata`=0xFFFF_FF80, `done` in cycle 4, `stall` high cycles 0–3.
- LHU at 0x102 with the same data -> `rdata`=0x0000_80FF; LH -> 0xFFFF_80FF; LW at 0x100 -> 0x80FF_1234.
- SB at 0x201 with wdata=0xDEAD_BEA5 -> `bus_we`=1, `bus_be`=0010, `bus_wdata`=0xA5A5_A5A5; SH at 0x202 -> `bus_be`=1100, `bus_wdata`=0xBEA5_BEA5.
- LW at 0x102, and separately DATAMEMControl=011 -> `bus_req` never asserts, `misalign_err`=`done`=1 in cycle 1, `rdata`=0.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> `bus_req` high for 4 cycles, then `bus_err`=`done`=1. Repeat with ack on the 4th cycle -> no `bus_err`.
- Assert `rst` in the second BUSY cycle -> next cycle all outputs 0, state IDLE. A following LW at 0x0 completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between an RV32I core and a word-wide memory bus.
// Optional feature macro: BUS_TIMEOUT_EN (aborts a BUSY access after TIMEOUT_CYCLES without ack).
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_write,
    input  logic [2:0]  DATAMEMControl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  ctl_r;
    logic [1:0]  ofs_r;
    logic        req_legal_s;
    logic        timeout_s;

    // Stores only use the signed size codes; halves need even, words need 4-byte alignment.
    function automatic logic is_legal(input logic we, input logic [2:0] ctl, input logic [1:0] ofs);
        logic ok;
        case (ctl)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~ofs[0];
            3'b010:  ok = (ofs == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~ofs[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] ctl, input logic [1:0] ofs);
        logic [3:0] be;
        case (ctl[1:0])
            2'b00:   be = 4'b0001 << ofs;
            2'b01:   be = ofs[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] ctl, input logic [31:0] d);
        logic [31:0] v;
        case (ctl[1:0])
            2'b00:   v = {4{d[7:0]}};
            2'b01:   v = {2{d[15:0]}};
            2'b10:   v = d;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] ctl, input logic [1:0] ofs,
                                             input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] v;
        shifted = word >> {ofs, 3'b000};
        half    = ofs[1] ? word[31:16] : word[15:0];
        case (ctl)
            3'b000:  v = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  v = {{16{half[15]}}, half};
            3'b010:  v = word;
            3'b100:  v = {24'h00_0000, shifted[7:0]};
            3'b101:  v = {16'h0000, half};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    assign req_legal_s = is_legal(mem_write, DATAMEMControl, addr[1:0]);
    assign stall       = ((state_r == IDLE) && req_valid) || (state_r == BUSY);

`ifdef BUS_TIMEOUT_EN
    logic [15:0] wait_cnt_r;

    // Terminal count is detected one cycle early so bus_req is high for exactly TIMEOUT_CYCLES cycles.
    assign timeout_s = (wait_cnt_r == 16'(TIMEOUT_CYCLES - 1));

    // Counts BUSY cycles without ack; idle clears it so each BUSY entry starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 16'h0000;
        end else if (state_r != BUSY) begin
            wait_cnt_r <= 16'h0000;
        end else if (!bus_ack) begin
            wait_cnt_r <= wait_cnt_r + 16'h0001;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ack takes priority over a coincident timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_s = req_legal_s ? BUSY : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (bus_ack || timeout_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Registered bus, completion and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            done         <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0000_0000;
            bus_be       <= 4'b0000;
            bus_wdata    <= 32'h0000_0000;
            rdata        <= 32'h0000_0000;
            ctl_r        <= 3'b000;
            ofs_r        <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    done         <= 1'b0;
                    misalign_err <= 1'b0;
                    bus_err      <= 1'b0;
                    if (req_valid) begin
                        ctl_r <= DATAMEMControl;
                        ofs_r <= addr[1:0];
                        if (req_legal_s) begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= byte_en(DATAMEMControl, addr[1:0]);
                            bus_wdata <= lane_data(DATAMEMControl, wdata);
                        end else begin
                            misalign_err <= 1'b1;
                            done         <= 1'b1;
                            rdata        <= 32'h0000_0000;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        done    <= 1'b1;
                        rdata   <= bus_we ? 32'h0000_0000 : load_fmt(ctl_r, ofs_r, bus_rdata);
                    end else if (timeout_s) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        done    <= 1'b1;
                        bus_err <= 1'b1;
                        rdata   <= 32'h0000_0000;
                    end
                end
                DONE: begin
                    done         <= 1'b0;
                    misalign_err <= 1'b0;
                    bus_err      <= 1'b0;
                end
                default: begin
                    done    <= 1'b0;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// compared against an arithmetic reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  ctl = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall, done, misalign_err, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int total = 0;
    int bad = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_write(mem_write),
        .DATAMEMControl(ctl), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .done(done), .misalign_err(misalign_err), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] c);
        return (c[1:0] == 2'd0) ? 1 : (c[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_legal(input bit we, input logic [2:0] c, input logic [31:0] a);
        bit code_ok;
        code_ok = (c == 3'd0 || c == 3'd1 || c == 3'd2) || (!we && (c == 3'd4 || c == 3'd5));
        return code_ok && ((a % size_of(c)) == 0);
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] c, input logic [31:0] a);
        longint v;
        v = ((longint'(1) << size_of(c)) - 1) << (a % 4);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [31:0] d);
        logic [31:0] r;
        longint b;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            b = (longint'(d) >> (8 * (i % size_of(c)))) & 255;
            r = r | (32'(b) << (8 * i));
        end
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a,
                                               input logic [31:0] w);
        int n;
        longint v;
        n = size_of(c);
        v = (longint'(w) >> (8 * (a % 4))) & ((longint'(1) << (8 * n)) - 1);
        if (c[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // One full access; k is the cycle in which ack is returned (k > TO means no ack).
    task automatic do_access(input bit we, input logic [2:0] c, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] word, input int k);
        bit legal;
        bit abort;
        int last;
        legal = model_legal(we, c, a);
`ifdef BUS_TIMEOUT_EN
        abort = (k > TO);
`else
        abort = 1'b0;
`endif
        last = abort ? TO : k;
        @(negedge clk);
        req_valid = 1'b1; mem_write = we; ctl = c; addr = a; wdata = d;
        #1 check_val("stall_c0", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        wdata = $urandom;
        if (!legal) begin
            check_val("ill_done", 32'(done), 32'd1);
            check_val("ill_mis", 32'(misalign_err), 32'd1);
            check_val("ill_req", 32'(bus_req), 32'd0);
            check_val("ill_rdata", rdata, 32'd0);
            check_val("ill_stall", 32'(stall), 32'd0);
            @(negedge clk);
            check_val("ill_done_end", 32'(done), 32'd0);
            check_val("ill_req_end", 32'(bus_req), 32'd0);
        end else begin
            for (int cyc = 1; cyc <= last; cyc++) begin
                check_val("busy_req", 32'(bus_req), 32'd1);
                check_val("busy_stall", 32'(stall), 32'd1);
                check_val("busy_done", 32'(done), 32'd0);
                check_val("busy_we", 32'(bus_we), 32'(we));
                check_val("busy_addr", bus_addr, a & 32'hFFFF_FFFC);
                check_val("busy_be", 32'(bus_be), model_be(c, a));
                if (we) check_val("busy_wdata", bus_wdata, model_wdata(c, d));
                if (cyc == k) begin
                    bus_ack = 1'b1;
                    bus_rdata = word;
                end else begin
                    bus_rdata = $urandom;
                end
                @(negedge clk);
                bus_ack = 1'b0;
            end
            check_val("fin_done", 32'(done), 32'd1);
            check_val("fin_buserr", 32'(bus_err), 32'(abort));
            check_val("fin_mis", 32'(misalign_err), 32'd0);
            check_val("fin_req", 32'(bus_req), 32'd0);
            check_val("fin_stall", 32'(stall), 32'd0);
            if (abort) check_val("fin_rdata_abort", rdata, 32'd0);
            else if (!we) check_val("fin_rdata", rdata, model_load(c, a, word));
            @(negedge clk);
            check_val("post_done", 32'(done), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_stall"}, 32'(stall), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_mis"}, 32'(misalign_err), 32'd0);
        check_val({tag, "_berr"}, 32'(bus_err), 32'd0);
        check_val({tag, "_req"}, 32'(bus_req), 32'd0);
        check_val({tag, "_we"}, 32'(bus_we), 32'd0);
        check_val({tag, "_addr"}, bus_addr, 32'd0);
        check_val({tag, "_be"}, 32'(bus_be), 32'd0);
        check_val({tag, "_wdata"}, bus_wdata, 32'd0);
        check_val({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Directed loads and stores on one data word.
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 3);
        do_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 1);
        do_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 2);
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'h80FF_1234, 1);
        do_access(1'b1, 3'b000, 32'h201, 32'hDEAD_BEA5, 32'h0, 2);
        do_access(1'b1, 3'b001, 32'h202, 32'hDEAD_BEA5, 32'h0, 1);
        do_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1);
        do_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1);
        do_access(1'b1, 3'b100, 32'h100, 32'h1, 32'h0, 1);

        // Stray ack while idle must not produce a completion.
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check_val("stray_ack_done", 32'(done), 32'd0);

`ifdef BUS_TIMEOUT_EN
        do_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h1234_5678, TO + 1);
        do_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h1234_5678, TO);
`endif

        // Reset during the second BUSY cycle abandons the access.
        @(negedge clk);
        req_valid = 1'b1; mem_write = 1'b0; ctl = 3'b010; addr = 32'h80;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("rst_busy_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        do_access(1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFE_F00D, 2);

        // Randomized accesses over all codes, offsets and ack latencies.
        for (int i = 0; i < 60; i++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, $urandom_range(1, TO + 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
